// File: rtl/imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Brief    : Boot loader that packs a byte stream little-endian into 32-bit
//             instruction-memory writes, then holds the CPU start level.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    input  logic              last_i,
    output logic              byte_ready_o,
    output logic              wr_en_o,
    output logic [31:0]       wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              start_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_count_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_RUN   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] c_WORDS = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_lane;
    logic [ADDR_W:0]   r_word_idx;
    logic [31:0]       r_asm;
    logic [31:0]       w_asm_nxt;
    logic              w_accept;
    logic              w_overflow;
    logic              w_reload;

    assign w_accept     = byte_valid_i & byte_ready_o;
    assign w_overflow   = (r_word_idx == c_WORDS);
    assign w_reload     = load_i & ((r_state == S_IDLE) | (r_state == S_RUN) | (r_state == S_ERR));
    assign word_count_o = r_word_idx;

    // Assembly register with the incoming byte dropped into the current lane
    always_comb begin
        w_asm_nxt = r_asm;
        w_asm_nxt[{r_lane, 3'b000} +: 8] = byte_i;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_RUN, S_ERR: begin
                if (load_i) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (w_overflow) begin
                        w_state_nxt = S_ERR;
                    end else if (last_i) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_lane       <= 2'd0;
            r_word_idx   <= '0;
            r_asm        <= 32'd0;
            byte_ready_o <= 1'b0;
            wr_en_o      <= 1'b0;
            wr_addr_o    <= 32'd0;
            wr_data_o    <= 32'd0;
            start_o      <= 1'b0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            byte_ready_o <= (w_state_nxt == S_LOAD);
            busy_o       <= (w_state_nxt == S_LOAD) | (w_state_nxt == S_DRAIN);
            start_o      <= (w_state_nxt == S_RUN);
            err_o        <= (w_state_nxt == S_ERR);
            wr_en_o      <= 1'b0;

            if (w_reload) begin
                r_lane     <= 2'd0;
                r_word_idx <= '0;
                r_asm      <= 32'd0;
            end else if ((r_state == S_LOAD) && w_accept && !w_overflow) begin
                if ((r_lane == 2'd3) || last_i) begin
                    // Word complete: emit it and start the next one from a clean slate
                    wr_en_o    <= 1'b1;
                    wr_addr_o  <= {{(29 - ADDR_W){1'b0}}, r_word_idx, 2'b00};
                    wr_data_o  <= w_asm_nxt;
                    r_word_idx <= r_word_idx + 1'b1;
                    r_lane     <= 2'd0;
                    r_asm      <= 32'd0;
                end else begin
                    r_asm      <= w_asm_nxt;
                    r_lane     <= r_lane + 2'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
